// File: rtl/tmr_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : tmr_multi_if
// Purpose  : Peripheral register-bus bundle for the multi-channel timer:
//            CPU access strobes, read data, interrupt and match pulses.
// Revision : 1.0 - initial release
// ============================================================================
interface tmr_multi_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int ADDR_W   = $clog2(CHANNELS) + 2
) ();
   logic [ADDR_W-1:0]   addr;
   logic [WIDTH-1:0]    wdata;
   logic                we;
   logic                re;
   logic [WIDTH-1:0]    rdata;
   logic                irq;
   logic [CHANNELS-1:0] match_pulse;

   // CPU side drives the access, timer side answers
   modport master (output addr, wdata, we, re, input rdata, irq, match_pulse);
   modport slave  (input addr, wdata, we, re, output rdata, irq, match_pulse);
endinterface
`default_nettype wire

// File: rtl/tmr_multi.sv
`default_nettype none
// ============================================================================
// Module   : tmr_multi
// Purpose  : CHANNELS independent WIDTH-bit up-counters, each with a 4-bit
//            prescaler, compare register, periodic/one-shot mode and sticky
//            MATCH flag. Register map per channel: 0 CNT, 1 STAT, 2 CTRL,
//            3 CMP. Optional feature macro: TMR_IRQ_EN (interrupt enable
//            bit CTRL[5] and the irq output; irq tied low when undefined).
// Revision : 1.0 - initial release
// ============================================================================
module tmr_multi #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int ADDR_W   = $clog2(CHANNELS) + 2
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   tmr_multi_if.slave bus
);
   localparam int CH_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;

   logic [CH_W-1:0]           w_ch_idx;
   logic                      w_in_range;
   logic [1:0]                w_reg_sel;
   logic [CHANNELS*WIDTH-1:0] w_cnt_all;
   logic [CHANNELS*WIDTH-1:0] w_stat_all;
   logic [CHANNELS*WIDTH-1:0] w_ctrl_all;
   logic [CHANNELS*WIDTH-1:0] w_cmp_all;
   logic [CHANNELS-1:0]       w_pulse_all;
   logic [WIDTH-1:0]          w_rd_val;
   logic [WIDTH-1:0]          rdata_q;
`ifdef TMR_IRQ_EN
   logic [CHANNELS-1:0]       w_irq_src;
`endif

   // A single-channel build has no channel field in the address
   generate
      if (ADDR_W > 2) begin : g_ch_field
         assign w_ch_idx = bus.addr[ADDR_W-1:2];
      end else begin : g_ch_none
         assign w_ch_idx = '0;
      end
   endgenerate

   assign w_reg_sel  = bus.addr[1:0];
   assign w_in_range = (int'(w_ch_idx) < CHANNELS);

   generate
      for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
         logic             w_sel, w_cnt_wr, w_stat_wr, w_ctrl_wr, w_cmp_wr;
         logic             w_tick, w_hit, w_ie;
         logic [WIDTH-1:0] cnt_q, cnt_d, cmp_q, cmp_d;
         logic [WIDTH-1:0] w_stat_rd, w_ctrl_rd;
         logic [3:0]       presc_q, presc_d, pcnt_q, pcnt_d;
         logic             en_q, en_d, oneshot_q, oneshot_d;
         logic             match_q, match_d, pulse_q, pulse_d;

         assign w_sel     = bus.we && w_in_range && (int'(w_ch_idx) == g);
         assign w_cnt_wr  = w_sel && (w_reg_sel == 2'd0);
         assign w_stat_wr = w_sel && (w_reg_sel == 2'd1);
         assign w_ctrl_wr = w_sel && (w_reg_sel == 2'd2);
         assign w_cmp_wr  = w_sel && (w_reg_sel == 2'd3);

         // A CNT write in the same cycle swallows the tick's compare match
         assign w_tick = en_q && (pcnt_q == presc_q);
         assign w_hit  = w_tick && !w_cnt_wr && (cnt_q == cmp_q);

         // Next-state: counter, prescaler, sticky flag and control fields
         always_comb begin
            cnt_d     = cnt_q;
            cmp_d     = cmp_q;
            presc_d   = presc_q;
            pcnt_d    = pcnt_q + 4'd1;
            en_d      = en_q;
            oneshot_d = oneshot_q;
            match_d   = match_q;
            pulse_d   = w_hit;

            if (w_cnt_wr || !en_q || w_tick) pcnt_d = '0;

            if (w_cnt_wr)    cnt_d = bus.wdata;
            else if (w_hit)  cnt_d = '0;
            else if (w_tick) cnt_d = cnt_q + 1'b1;

            // Hardware set wins over a same-cycle write-1-to-clear
            if (w_hit)                          match_d = 1'b1;
            else if (w_stat_wr && bus.wdata[0]) match_d = 1'b0;

            // CPU write to CTRL wins over the one-shot self-disable
            if (w_ctrl_wr) begin
               en_d      = bus.wdata[7];
               oneshot_d = bus.wdata[6];
               presc_d   = bus.wdata[3:0];
            end else if (w_hit && oneshot_q) begin
               en_d = 1'b0;
            end

            if (w_cmp_wr) cmp_d = bus.wdata;
         end

         // Channel state register
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               cnt_q     <= '0;
               cmp_q     <= '0;
               presc_q   <= '0;
               pcnt_q    <= '0;
               en_q      <= 1'b0;
               oneshot_q <= 1'b0;
               match_q   <= 1'b0;
               pulse_q   <= 1'b0;
            end else begin
               cnt_q     <= cnt_d;
               cmp_q     <= cmp_d;
               presc_q   <= presc_d;
               pcnt_q    <= pcnt_d;
               en_q      <= en_d;
               oneshot_q <= oneshot_d;
               match_q   <= match_d;
               pulse_q   <= pulse_d;
            end
         end

`ifdef TMR_IRQ_EN
         logic ie_q;

         // Interrupt-enable bit, only present in interrupt-capable builds
         always_ff @(posedge clk) begin
            if (!rst_n)         ie_q <= 1'b0;
            else if (w_ctrl_wr) ie_q <= bus.wdata[5];
         end
         assign w_ie         = ie_q;
         assign w_irq_src[g] = match_q & ie_q;
`else
         assign w_ie = 1'b0;
`endif

         // Readback images with unused bits forced to zero
         always_comb begin
            w_stat_rd      = '0;
            w_stat_rd[0]   = match_q;
            w_ctrl_rd      = '0;
            w_ctrl_rd[7:0] = {en_q, oneshot_q, w_ie, 1'b0, presc_q};
         end

         assign w_cnt_all[g*WIDTH +: WIDTH]  = cnt_q;
         assign w_stat_all[g*WIDTH +: WIDTH] = w_stat_rd;
         assign w_ctrl_all[g*WIDTH +: WIDTH] = w_ctrl_rd;
         assign w_cmp_all[g*WIDTH +: WIDTH]  = cmp_q;
         assign w_pulse_all[g]               = pulse_q;
      end
   endgenerate

   // Read mux; out-of-range channels read as zero
   always_comb begin
      w_rd_val = '0;
      if (w_in_range) begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (int'(w_ch_idx) == c) begin
               case (w_reg_sel)
                  2'd0:    w_rd_val = w_cnt_all[c*WIDTH +: WIDTH];
                  2'd1:    w_rd_val = w_stat_all[c*WIDTH +: WIDTH];
                  2'd2:    w_rd_val = w_ctrl_all[c*WIDTH +: WIDTH];
                  default: w_rd_val = w_cmp_all[c*WIDTH +: WIDTH];
               endcase
            end
         end
      end
   end

   // Registered read data, held until the next read strobe
   always_ff @(posedge clk) begin
      if (!rst_n)      rdata_q <= '0;
      else if (bus.re) rdata_q <= w_rd_val;
   end

   assign bus.rdata       = rdata_q;
   assign bus.match_pulse = w_pulse_all;
`ifdef TMR_IRQ_EN
   assign bus.irq = |w_irq_src;
`else
   assign bus.irq = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_tmr_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmr_multi
// Purpose  : Self-checking bench for tmr_multi. Instance A: WIDTH 8,
//            4 channels. Instance B: WIDTH 16, 2 channels with a 4-bit
//            address so that unimplemented channel indices can be reached.
//            Expected counts and pulses come from closed-form timing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmr_multi;
   logic clk = 1'b0;
   logic rst_n;
   int   nvec = 0;
   int   nerr = 0;

`ifdef TMR_IRQ_EN
   localparam bit IRQ_IMPL = 1'b1;
`else
   localparam bit IRQ_IMPL = 1'b0;
`endif

   always #5 clk = ~clk;

   tmr_multi_if #(.WIDTH(8),  .CHANNELS(4), .ADDR_W(4)) bus_a ();
   tmr_multi_if #(.WIDTH(16), .CHANNELS(2), .ADDR_W(4)) bus_b ();

   tmr_multi #(.WIDTH(8),  .CHANNELS(4), .ADDR_W(4)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   tmr_multi #(.WIDTH(16), .CHANNELS(2), .ADDR_W(4)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   // ---------------- bus helpers (no checking inside) ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] ra(input int ch, input int r);
      return 4'(ch * 4 + r);
   endfunction

   task automatic wr_a(input logic [3:0] a, input logic [7:0] d);
      bus_a.addr = a; bus_a.wdata = d; bus_a.we = 1'b1;
      cyc();
      bus_a.we = 1'b0;
   endtask

   task automatic rd_a(input logic [3:0] a, output logic [7:0] d);
      bus_a.addr = a; bus_a.re = 1'b1;
      cyc();
      bus_a.re = 1'b0;
      d = bus_a.rdata;
   endtask

   task automatic wr_b(input logic [3:0] a, input logic [15:0] d);
      bus_b.addr = a; bus_b.wdata = d; bus_b.we = 1'b1;
      cyc();
      bus_b.we = 1'b0;
   endtask

   task automatic rd_b(input logic [3:0] a, output logic [15:0] d);
      bus_b.addr = a; bus_b.re = 1'b1;
      cyc();
      bus_b.re = 1'b0;
      d = bus_b.rdata;
   endtask

   // Disable, zero, program and enable one channel of instance A.
   // Returns just after the edge that commits the CTRL write (m = 0).
   task automatic setup_a(input int ch, input int cmp, input int ctrl);
      wr_a(ra(ch, 2), 8'h00);
      wr_a(ra(ch, 0), 8'h00);
      wr_a(ra(ch, 3), 8'(cmp));
      wr_a(ra(ch, 1), 8'h01);
      wr_a(ra(ch, 2), 8'(ctrl));
   endtask

   // ---------------- reference model: closed-form timing ----------------
   // m cycles after enabling from CNT = 0: ticks happen every P+1 cycles,
   // the count runs 0..CMP and wraps on the tick that finds CNT == CMP.
   function automatic int exp_cnt(input int m, input int cmp, input int p);
      return (m / (p + 1)) % (cmp + 1);
   endfunction

   function automatic bit exp_pulse(input int m, input int cmp, input int p);
      int n;
      if (m == 0 || (m % (p + 1)) != 0) return 1'b0;
      n = m / (p + 1);
      return (n % (cmp + 1)) == 0;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [7:0]  da;
      logic [15:0] db;
      rst_n = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
      nvec++; if (bus_a.rdata !== 8'h00) begin nerr++; $display("FAIL reset_rdata_a: got %0h expected 0", bus_a.rdata); end
      nvec++; if (bus_a.irq !== 1'b0) begin nerr++; $display("FAIL reset_irq_a: got %0b expected 0", bus_a.irq); end
      nvec++; if (bus_a.match_pulse !== 4'h0) begin nerr++; $display("FAIL reset_pulse_a: got %0h expected 0", bus_a.match_pulse); end
      nvec++; if (bus_b.irq !== 1'b0) begin nerr++; $display("FAIL reset_irq_b: got %0b expected 0", bus_b.irq); end
      for (int a = 0; a < 16; a++) begin
         rd_a(4'(a), da);
         nvec++; if (da !== 8'h00) begin nerr++; $display("FAIL reset_reg_a[%0d]: got %0h expected 0", a, da); end
      end
      for (int a = 0; a < 8; a++) begin
         rd_b(4'(a), db);
         nvec++; if (db !== 16'h0000) begin nerr++; $display("FAIL reset_reg_b[%0d]: got %0h expected 0", a, db); end
      end
   endtask

   task automatic test_periodic(input int ch, input int cmp, input int p);
      int         len;
      logic [7:0] d;
      setup_a(ch, cmp, 8'h80 | p);
      len = (cmp + 1) * (p + 1) * 2 + 3;
      bus_a.addr = ra(ch, 0);
      bus_a.re   = 1'b1;
      for (int m = 0; m < len; m++) begin
         nvec++;
         if (bus_a.match_pulse[ch] !== exp_pulse(m, cmp, p)) begin
            nerr++; $display("FAIL periodic_pulse ch%0d cmp%0d p%0d m%0d: got %0b expected %0b", ch, cmp, p, m, bus_a.match_pulse[ch], exp_pulse(m, cmp, p));
         end
         cyc();
         nvec++;
         if (bus_a.rdata !== 8'(exp_cnt(m, cmp, p))) begin
            nerr++; $display("FAIL periodic_cnt ch%0d cmp%0d p%0d m%0d: got %0h expected %0h", ch, cmp, p, m, bus_a.rdata, exp_cnt(m, cmp, p));
         end
      end
      bus_a.re = 1'b0;
      rd_a(ra(ch, 1), d);
      nvec++; if (d !== 8'h01) begin nerr++; $display("FAIL periodic_stat ch%0d: got %0h expected 1", ch, d); end
      wr_a(ra(ch, 2), 8'h00);
   endtask

   task automatic test_oneshot();
      logic [7:0] d;
      setup_a(1, 3, 8'hE2);
      for (int m = 0; m < 16; m++) begin
         nvec++;
         if (bus_a.match_pulse[1] !== (m == 12)) begin
            nerr++; $display("FAIL oneshot_pulse m%0d: got %0b expected %0b", m, bus_a.match_pulse[1], (m == 12));
         end
         nvec++;
         if (bus_a.irq !== (IRQ_IMPL && m >= 12)) begin
            nerr++; $display("FAIL oneshot_irq m%0d: got %0b expected %0b", m, bus_a.irq, (IRQ_IMPL && m >= 12));
         end
         cyc();
      end
      rd_a(ra(1, 2), d);
      nvec++; if (d !== (IRQ_IMPL ? 8'h62 : 8'h42)) begin nerr++; $display("FAIL oneshot_ctrl: got %0h expected %0h", d, (IRQ_IMPL ? 8'h62 : 8'h42)); end
      rd_a(ra(1, 0), d);
      nvec++; if (d !== 8'h00) begin nerr++; $display("FAIL oneshot_cnt: got %0h expected 0", d); end
      rd_a(ra(1, 1), d);
      nvec++; if (d !== 8'h01) begin nerr++; $display("FAIL oneshot_stat: got %0h expected 1", d); end
      wr_a(ra(1, 1), 8'h01);
      nvec++; if (bus_a.irq !== 1'b0) begin nerr++; $display("FAIL oneshot_irq_clear: got %0b expected 0", bus_a.irq); end
      rd_a(ra(1, 1), d);
      nvec++; if (d !== 8'h00) begin nerr++; $display("FAIL oneshot_stat_clear: got %0h expected 0", d); end
   endtask

   task automatic test_cnt_write_priority();
      logic [7:0] d;
      setup_a(2, 4, 8'h80);
      repeat (4) cyc();
      wr_a(ra(2, 0), 8'h40);   // commits on the tick that finds CNT == CMP
      nvec++; if (bus_a.match_pulse[2] !== 1'b0) begin nerr++; $display("FAIL cntwr_pulse: got %0b expected 0", bus_a.match_pulse[2]); end
      rd_a(ra(2, 0), d);
      nvec++; if (d !== 8'h40) begin nerr++; $display("FAIL cntwr_cnt: got %0h expected 40", d); end
      rd_a(ra(2, 1), d);
      nvec++; if (d !== 8'h00) begin nerr++; $display("FAIL cntwr_stat: got %0h expected 0", d); end
      wr_a(ra(2, 2), 8'h00);
   endtask

   task automatic test_w1c_priority();
      logic [7:0] d;
      setup_a(3, 2, 8'h80);
      repeat (2) cyc();
      wr_a(ra(3, 1), 8'h01);   // commits on the edge that sets MATCH
      nvec++; if (bus_a.match_pulse[3] !== 1'b1) begin nerr++; $display("FAIL w1c_pulse: got %0b expected 1", bus_a.match_pulse[3]); end
      rd_a(ra(3, 1), d);
      nvec++; if (d !== 8'h01) begin nerr++; $display("FAIL w1c_set_wins: got %0h expected 1", d); end
      wr_a(ra(3, 1), 8'h01);   // no match on this edge: clear takes effect
      rd_a(ra(3, 1), d);
      nvec++; if (d !== 8'h00) begin nerr++; $display("FAIL w1c_clear: got %0h expected 0", d); end
      wr_a(ra(3, 2), 8'h00);
   endtask

   task automatic test_read_during_write();
      logic [7:0] d;
      wr_a(ra(1, 3), 8'h11);
      bus_a.addr = ra(1, 3); bus_a.wdata = 8'h22; bus_a.we = 1'b1; bus_a.re = 1'b1;
      cyc();
      bus_a.we = 1'b0; bus_a.re = 1'b0;
      nvec++; if (bus_a.rdata !== 8'h11) begin nerr++; $display("FAIL rdw_old: got %0h expected 11", bus_a.rdata); end
      rd_a(ra(1, 3), d);
      nvec++; if (d !== 8'h22) begin nerr++; $display("FAIL rdw_new: got %0h expected 22", d); end
      wr_a(ra(1, 2), 8'h3F);
      rd_a(ra(1, 2), d);
      nvec++; if (d !== (IRQ_IMPL ? 8'h2F : 8'h0F)) begin nerr++; $display("FAIL ctrl_mask: got %0h expected %0h", d, (IRQ_IMPL ? 8'h2F : 8'h0F)); end
      wr_a(ra(1, 2), 8'h00);
   endtask

   task automatic test_random();
      int ch, cmp, p;
      for (int it = 0; it < 6; it++) begin
         ch  = int'($urandom_range(0, 3));
         cmp = int'($urandom_range(0, 6));
         p   = int'($urandom_range(0, 3));
         test_periodic(ch, cmp, p);
      end
   endtask

   task automatic test_wide();
      logic [15:0] d;
      int          v;
      wr_b(4'h2, 16'h0000);
      wr_b(4'h3, 16'hFFFF);
      wr_b(4'h0, 16'hFFFD);
      wr_b(4'h1, 16'h0001);
      wr_b(4'h2, 16'h0080);
      bus_b.addr = 4'h0;
      bus_b.re   = 1'b1;
      for (int m = 0; m < 6; m++) begin
         v = 32'hFFFD + m;
         nvec++;
         if (bus_b.match_pulse[0] !== (v == 32'h10000)) begin
            nerr++; $display("FAIL wide_pulse m%0d: got %0b expected %0b", m, bus_b.match_pulse[0], (v == 32'h10000));
         end
         cyc();
         nvec++;
         if (bus_b.rdata !== 16'(v)) begin
            nerr++; $display("FAIL wide_cnt m%0d: got %0h expected %0h", m, bus_b.rdata, 16'(v));
         end
      end
      bus_b.re = 1'b0;
      rd_b(4'h1, d);
      nvec++; if (d !== 16'h0001) begin nerr++; $display("FAIL wide_stat: got %0h expected 1", d); end
      wr_b(4'h2, 16'h0000);
      wr_b(4'hF, 16'h1234);
      wr_b(4'hC, 16'h5A5A);
      rd_b(4'hF, d);
      nvec++; if (d !== 16'h0000) begin nerr++; $display("FAIL oor_cmp3: got %0h expected 0", d); end
      rd_b(4'hC, d);
      nvec++; if (d !== 16'h0000) begin nerr++; $display("FAIL oor_cnt3: got %0h expected 0", d); end
      rd_b(4'h7, d);
      nvec++; if (d !== 16'h0000) begin nerr++; $display("FAIL oor_alias_cmp1: got %0h expected 0", d); end
      rd_b(4'h4, d);
      nvec++; if (d !== 16'h0000) begin nerr++; $display("FAIL oor_alias_cnt1: got %0h expected 0", d); end
   endtask

   task automatic test_reset_midcount();
      logic [7:0] d;
      setup_a(2, 1, 8'h87);
      repeat (15) cyc();
      rst_n = 1'b0;             // reset lands on the edge of the first match
      cyc();
      rst_n = 1'b1;
      nvec++; if (bus_a.match_pulse !== 4'h0) begin nerr++; $display("FAIL rstmid_pulse0: got %0h expected 0", bus_a.match_pulse); end
      nvec++; if (bus_a.irq !== 1'b0) begin nerr++; $display("FAIL rstmid_irq: got %0b expected 0", bus_a.irq); end
      for (int i = 0; i < 20; i++) begin
         cyc();
         nvec++; if (bus_a.match_pulse !== 4'h0) begin nerr++; $display("FAIL rstmid_pulse c%0d: got %0h expected 0", i, bus_a.match_pulse); end
      end
      for (int a = 0; a < 16; a++) begin
         rd_a(4'(a), d);
         nvec++; if (d !== 8'h00) begin nerr++; $display("FAIL rstmid_reg[%0d]: got %0h expected 0", a, d); end
      end
   endtask

   // Guard against a stalled simulation
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      bus_a.addr  = '0; bus_a.wdata = '0; bus_a.we = 1'b0; bus_a.re = 1'b0;
      bus_b.addr  = '0; bus_b.wdata = '0; bus_b.we = 1'b0; bus_b.re = 1'b0;
      test_reset();
      test_periodic(0, 5, 0);
      test_oneshot();
      test_cnt_write_priority();
      test_w1c_priority();
      test_read_during_write();
      test_random();
      test_wide();
      test_reset_midcount();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/tmr_multi.md
# tmr_multi

Multi-channel, parametrised successor to the SoC's single 8-bit timer. It provides CHANNELS independent up-counters of WIDTH bits, each with its own prescaler, compare register, periodic/one-shot mode and sticky match flag. It sits on the CPU peripheral register bus next to the UART and GPIO, and drives a combined interrupt line. Channel register layout keeps the legacy ordering (0 = count, 2 = control with enable at bit 7, 3 = compare), so existing firmware maps to channel 0 unchanged.

## Interface
- WIDTH, 8, counter/compare/bus data width; must be ≥ 8.
- CHANNELS, 4, number of timer channels; 1 to 16.
- ADDR_W, $clog2(CHANNELS)+2, register address width.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- addr  in  ADDR_W  register address: channel = addr[ADDR_W-1:2], register = addr[1:0].
- wdata  in  WIDTH  write data.
- we  in  1  write strobe, one access per cycle.
- re  in  1  read strobe.
- rdata  out  WIDTH  read data, registered.
- irq  out  1  OR over channels of (MATCH & IE).
- match_pulse  out  CHANNELS  one-cycle pulse per channel on compare match.

## Operation
- Per-channel registers:
  - 0 CNT: read/write; a write loads the counter.
  - 1 STAT: bit0 MATCH, sticky; writing 1 clears it.
  - 2 CTRL: [7] EN, [6] ONESHOT, [5] IE, [3:0] PRESC.
  - 3 CMP: read/write.
  - Unused bits read 0.
- Prescaler: a 4-bit counter per channel produces a tick when presc_cnt == PRESC, then returns to 0.
  - It runs only while EN = 1 and is held at 0 while EN = 0.
  - PRESC = 0 gives a tick every cycle (legacy behaviour).
- Counting, on a tick with EN = 1:
  - If CNT == CMP: CNT ← 0, MATCH ← 1, match_pulse[ch] = 1 for that cycle, and if ONESHOT = 1 then EN ← 0.
  - Otherwise CNT ← CNT + 1, modulo 2^WIDTH.
- With CMP = all-ones, the counter wraps naturally and MATCH is set on the wrap.
- Writes to CTRL, CMP and STAT take effect from the next cycle.
- Priorities within one cycle:
  - A CNT write beats a tick: the written value is loaded, the match for that cycle is suppressed, and presc_cnt is reset to 0.
  - MATCH set beats a simultaneous write-1-to-clear.
  - If a hardware one-shot clear of EN coincides with a CPU write to CTRL, the CPU write wins.
- Accesses to channel indices ≥ CHANNELS: writes are ignored; reads return 0.
- Reset values (rst_n = 0 at a clock edge): every CNT, CMP, CTRL, STAT and prescaler is 0; rdata = 0; irq = 0; match_pulse = 0.
- Reset asserted mid-count aborts the count immediately, with no residual pulse.

## Timing
- Read latency is 1 cycle: rdata is valid on the cycle after re and holds until the next read.
- Read-during-write to the same register returns the pre-write value.
- Enabling a channel with PRESC = P produces the first tick P+1 cycles after the CTRL write is committed.
- Match period is (CMP+1)·(PRESC+1) cycles.
- irq rises in the cycle after the match edge, because it is derived from the registered MATCH and IE bits.
- match_pulse is asserted in the same cycle that CNT becomes 0.
- No combinational path from bus inputs to irq or match_pulse.

## Configuration
- TMR_IRQ_EN defined:
  - IE is implemented.
  - irq is driven as specified above.
- TMR_IRQ_EN undefined:
  - CTRL[5] is not stored and reads 0.
  - irq is tied to 0.
  - MATCH, STAT and match_pulse behave identically to the defined case.

## Test plan
- Reset → read all registers of every channel → all return 0; irq = 0.
- Channel 0: CMP = 5, CTRL = 0x80 → CNT sequence 0,1,…,5,0. match_pulse[0] fires every 6 cycles, and STAT reads 1 after the first wrap.
- Channel 1: CMP = 3, PRESC = 2, ONESHOT = 1, IE = 1 → MATCH after 12 cycles. EN self-clears, CNT stays 0 and irq = 1. Writing STAT = 1 drops irq the next cycle.
- Simultaneous CNT write of 0x40 and tick at CNT == CMP → CNT = 0x40, no match_pulse. A write-1-to-clear in the cycle MATCH is set → MATCH stays 1.
- WIDTH = 16, CHANNELS = 2, CMP = 0xFFFF → wrap 0xFFFF → 0 with MATCH set. A write to channel index 3 is ignored, and a read from it returns 0.
- rst_n low for one cycle while channel 2 is mid-count with PRESC = 7 → all state is 0 on the next cycle, and no match_pulse follows.
